// File: rtl/decode_issue_buffer_pkg.sv
// decode_issue_buffer_pkg
//   Shared widths, the buffered lane record and the modulo pointer helper used by the
//   decode issue buffer and its interface.
package decode_issue_buffer_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;
   localparam logic [ILEN-1:0] ENDSIM_INST_DEFAULT = 32'h0000_006b;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } lane_t;

   // ptr < depth and inc <= depth, so one conditional subtract wraps correctly for any depth,
   // including non-power-of-two ones.
   function automatic int unsigned ptr_wrap_add(input int unsigned ptr, input int unsigned inc,
                                                input int unsigned depth);
      int unsigned sum;
      sum = ptr + inc;
      if (sum >= depth) sum = sum - depth;
      return sum;
   endfunction

endpackage

// File: rtl/decode_issue_buffer_if.sv
// decode_issue_buffer_if
//   Bundles the fetch-side, issue-side and decoder-side signals of the decode issue buffer.
//   master: upstream/downstream environment (drives fetch group, flush, issue count).
//   slave : the buffer itself.
//   Signals: flush_decoder_i, f1_valid_i/pc_i/inst_i, f1_ready_o, issue_cnt_i,
//            decoder_valid_o/pc_o/inst_o/endsim_o, occupancy_o.
interface decode_issue_buffer_if
   import decode_issue_buffer_pkg::*;
#(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 4
);
   logic                              flush_decoder_i;
   logic [WIDTH-1:0]                  f1_valid_i;
   logic [WIDTH*XLEN-1:0]             f1_pc_i;
   logic [WIDTH*ILEN-1:0]             f1_inst_i;
   logic                              f1_ready_o;
   logic [$clog2(WIDTH+1)-1:0]        issue_cnt_i;
   logic [WIDTH-1:0]                  decoder_valid_o;
   logic [WIDTH*XLEN-1:0]             decoder_pc_o;
   logic [WIDTH*ILEN-1:0]             decoder_inst_o;
   logic [WIDTH-1:0]                  decoder_endsim_o;
   logic [$clog2(DEPTH+1)-1:0]        occupancy_o;

   modport master (
      output flush_decoder_i, f1_valid_i, f1_pc_i, f1_inst_i, issue_cnt_i,
      input  f1_ready_o, decoder_valid_o, decoder_pc_o, decoder_inst_o, decoder_endsim_o,
             occupancy_o
   );

   modport slave (
      input  flush_decoder_i, f1_valid_i, f1_pc_i, f1_inst_i, issue_cnt_i,
      output f1_ready_o, decoder_valid_o, decoder_pc_o, decoder_inst_o, decoder_endsim_o,
             occupancy_o
   );

endinterface

// File: rtl/decode_issue_buffer_lane_prefix_count.sv
// decode_issue_buffer_lane_prefix_count
//   Length of the contiguous run of set bits starting at lane 0 of a valid vector.
//   Ports: valid (WIDTH lane valids, lane 0 oldest), count (prefix length, 0..WIDTH).
module decode_issue_buffer_lane_prefix_count #(
   parameter int unsigned WIDTH = 2
) (
   input  logic [WIDTH-1:0]           valid,
   output logic [$clog2(WIDTH+1)-1:0] count
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic run;

   always_comb begin
      count = '0;
      run   = 1'b1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         run = run & valid[i];
         if (run) count = count + CW'(1);
      end
   end

endmodule

// File: rtl/decode_issue_buffer.sv
// decode_issue_buffer
//   Circular queue of DEPTH fetched instructions between the fetch queue and the per-lane
//   decoders. Accepts whole fetch groups, presents the oldest WIDTH entries, retires the
//   in-order prefix the issue logic consumes each cycle.
//   Ports: clk, rst_n (async active-low), bus (decode_issue_buffer_if.slave).
module decode_issue_buffer
   import decode_issue_buffer_pkg::*;
#(
   parameter int unsigned     WIDTH       = 2,
   parameter int unsigned     DEPTH       = 4,
   parameter logic [ILEN-1:0] ENDSIM_INST = ENDSIM_INST_DEFAULT
) (
   input logic                  clk,
   input logic                  rst_n,
   decode_issue_buffer_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned OW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [OW-1:0] READY_MAX = OW'(DEPTH - WIDTH);

   lane_t         entries_q [DEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [OW-1:0] occ_q, occ_d;

   logic [CW-1:0] enq_k, k_acc, avail, deq;
   logic          ready;
   logic [PW-1:0] wr_idx [WIDTH];
   logic [PW-1:0] rd_idx [WIDTH];

   decode_issue_buffer_lane_prefix_count #(
      .WIDTH (WIDTH)
   ) u_prefix (
      .valid (bus.f1_valid_i),
      .count (enq_k)
   );

   // Ready looks only at registered occupancy: space freed by this cycle's issue is not reused
   // until the next cycle, keeping issue_cnt_i off the fetch handshake path.
   assign ready = !bus.flush_decoder_i && (occ_q <= READY_MAX);
   assign k_acc = ready ? enq_k : '0;

   // Valid head lanes = min(occ, WIDTH); issue count is clipped to it.
   assign avail = (occ_q >= OW'(WIDTH)) ? CW'(WIDTH) : CW'(occ_q);
   assign deq   = bus.flush_decoder_i ? '0 :
                  ((bus.issue_cnt_i < avail) ? bus.issue_cnt_i : avail);
   assign occ_d = occ_q + OW'(k_acc) - OW'(deq);

   always_comb begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
         wr_idx[j] = PW'(ptr_wrap_add(32'(tail_q), j, DEPTH));
         rd_idx[j] = PW'(ptr_wrap_add(32'(head_q), j, DEPTH));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      end else if (bus.flush_decoder_i) begin
         // Entry contents are left stale; only the pointers matter.
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         for (int unsigned j = 0; j < WIDTH; j++) begin
            if (j < 32'(k_acc)) begin
               entries_q[wr_idx[j]] <= '{pc:   bus.f1_pc_i[j*XLEN +: XLEN],
                                         inst: bus.f1_inst_i[j*ILEN +: ILEN]};
            end
         end
         tail_q <= PW'(ptr_wrap_add(32'(tail_q), 32'(k_acc), DEPTH));
         head_q <= PW'(ptr_wrap_add(32'(head_q), 32'(deq), DEPTH));
         occ_q  <= occ_d;
      end
   end

   always_comb begin
      bus.decoder_valid_o  = '0;
      bus.decoder_endsim_o = '0;
      bus.decoder_pc_o     = '0;
      bus.decoder_inst_o   = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
         if (32'(occ_q) > j) begin
            bus.decoder_pc_o[j*XLEN +: XLEN]   = entries_q[rd_idx[j]].pc;
            bus.decoder_inst_o[j*ILEN +: ILEN] = entries_q[rd_idx[j]].inst;
            bus.decoder_valid_o[j]             = !bus.flush_decoder_i;
            bus.decoder_endsim_o[j]            = !bus.flush_decoder_i &&
                                                 (entries_q[rd_idx[j]].inst == ENDSIM_INST);
         end
      end
   end

   assign bus.f1_ready_o  = ready;
   assign bus.occupancy_o = occ_q;

   // Issue logic must never consume more lanes than are presented valid.
   a_issue_within_valid: assert property (@(posedge clk) disable iff (!rst_n)
      !bus.flush_decoder_i |-> (bus.issue_cnt_i <= avail))
      else $error("issue_cnt_i exceeds valid head lanes");

endmodule

// File: tb/tb_decode_issue_buffer.sv
// tb_decode_issue_buffer
//   Directed vector table plus randomized traffic against a queue-based reference model.
module tb_decode_issue_buffer;
   import decode_issue_buffer_pkg::*;

   localparam int unsigned WIDTH = 2;
   localparam int unsigned DEPTH = 4;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   decode_issue_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   decode_issue_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic [1:0]  valid;
      logic [63:0] pc0, pc1;
      logic [31:0] inst0, inst1;
      logic [1:0]  issue;
      logic [1:0]  e_valid;
      logic        e_ready;
      logic [2:0]  e_occ;
      logic [63:0] e_pc0, e_pc1;
      logic [1:0]  e_endsim;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(input logic fl, input logic [1:0] v, input logic [63:0] p0,
                               input logic [63:0] p1, input logic [31:0] i0,
                               input logic [31:0] i1, input logic [1:0] is,
                               input logic [1:0] ev, input logic er, input logic [2:0] eo,
                               input logic [63:0] ep0, input logic [63:0] ep1,
                               input logic [1:0] ee);
      vec_t r;
      r.flush = fl; r.valid = v; r.pc0 = p0; r.pc1 = p1; r.inst0 = i0; r.inst1 = i1;
      r.issue = is; r.e_valid = ev; r.e_ready = er; r.e_occ = eo; r.e_pc0 = ep0;
      r.e_pc1 = ep1; r.e_endsim = ee;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic fl, input logic [1:0] v, input logic [63:0] p0,
                        input logic [63:0] p1, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [1:0] is);
      bus.flush_decoder_i = fl;
      bus.f1_valid_i      = v;
      bus.f1_pc_i         = {p1, p0};
      bus.f1_inst_i       = {i1, i0};
      bus.issue_cnt_i     = is;
   endtask

   logic [95:0] mq [$];   // reference queue, {pc, inst}, oldest first

   initial begin
      localparam logic [31:0] NOP = 32'h13;
      localparam logic [31:0] END = 32'h6b;
      clk = 1'b0;
      rst_n = 1'b0;
      errors = 0;
      checks = 0;
      drive(1'b0, 2'b00, 64'h0, 64'h0, NOP, NOP, 2'd0);

      // Reset held, then released mid-cycle.
      @(posedge clk); #1;
      chk("reset_valid", 64'(bus.decoder_valid_o), 64'h0);
      chk("reset_ready", 64'(bus.f1_ready_o), 64'h1);
      chk("reset_occ", 64'(bus.occupancy_o), 64'h0);
      #3 rst_n = 1'b1;
      #1;
      chk("release_occ", 64'(bus.occupancy_o), 64'h0);
      chk("release_valid", 64'(bus.decoder_valid_o), 64'h0);
      @(posedge clk); #1;

      //              fl  v      pc0        pc1        i0   i1   is | ev   r  occ  epc0       epc1     es
      tbl[0]  = mk(0, 2'b11, 64'h1000, 64'h1004, NOP, NOP, 0, 2'b00, 1, 0, 64'h0, 64'h0, 2'b00);
      tbl[1]  = mk(0, 2'b01, 64'h1008, 64'h0, NOP, NOP, 0, 2'b11, 1, 2, 64'h1000, 64'h1004, 0);
      tbl[2]  = mk(0, 2'b11, 64'h2000, 64'h2004, NOP, NOP, 1, 2'b11, 0, 3, 64'h1000, 64'h1004, 0);
      tbl[3]  = mk(0, 2'b10, 64'h2008, 64'h200c, NOP, NOP, 0, 2'b11, 1, 2, 64'h1004, 64'h1008, 0);
      tbl[4]  = mk(0, 2'b11, 64'h3000, 64'h3004, NOP, NOP, 0, 2'b11, 1, 2, 64'h1004, 64'h1008, 0);
      tbl[5]  = mk(0, 2'b11, 64'h4000, 64'h4004, NOP, NOP, 2, 2'b11, 0, 4, 64'h1004, 64'h1008, 0);
      tbl[6]  = mk(1, 2'b11, 64'h5000, 64'h5004, NOP, NOP, 2, 2'b00, 0, 2, 64'h3000, 64'h3004, 0);
      tbl[7]  = mk(0, 2'b00, 64'h0, 64'h0, NOP, NOP, 0, 2'b00, 1, 0, 64'h0, 64'h0, 0);
      tbl[8]  = mk(0, 2'b11, 64'h100, 64'h104, NOP, NOP, 0, 2'b00, 1, 0, 64'h0, 64'h0, 0);
      tbl[9]  = mk(0, 2'b01, 64'h108, 64'h0, NOP, NOP, 0, 2'b11, 1, 2, 64'h100, 64'h104, 0);
      tbl[10] = mk(0, 2'b00, 64'h0, 64'h0, NOP, NOP, 2, 2'b11, 0, 3, 64'h100, 64'h104, 0);
      tbl[11] = mk(0, 2'b00, 64'h0, 64'h0, NOP, NOP, 1, 2'b01, 1, 1, 64'h108, 64'h0, 0);
      tbl[12] = mk(0, 2'b11, 64'h2000, 64'h2004, NOP, END, 0, 2'b00, 1, 0, 64'h0, 64'h0, 0);
      tbl[13] = mk(0, 2'b00, 64'h0, 64'h0, NOP, NOP, 2, 2'b11, 1, 2, 64'h2000, 64'h2004, 2'b10);
      tbl[14] = mk(0, 2'b01, 64'h3000, 64'h3004, NOP, END, 0, 2'b00, 1, 0, 64'h0, 64'h0, 0);
      tbl[15] = mk(0, 2'b00, 64'h0, 64'h0, NOP, NOP, 0, 2'b01, 1, 1, 64'h3000, 64'h0, 0);
      tbl[16] = mk(1, 2'b11, 64'h5000, 64'h5004, END, END, 1, 2'b00, 0, 1, 64'h3000, 64'h0, 0);
      tbl[17] = mk(0, 2'b00, 64'h0, 64'h0, NOP, NOP, 0, 2'b00, 1, 0, 64'h0, 64'h0, 0);

      for (int r = 0; r < 18; r++) begin
         drive(tbl[r].flush, tbl[r].valid, tbl[r].pc0, tbl[r].pc1, tbl[r].inst0, tbl[r].inst1,
               tbl[r].issue);
         #2;
         chk($sformatf("vec%0d_valid", r), 64'(bus.decoder_valid_o), 64'(tbl[r].e_valid));
         chk($sformatf("vec%0d_ready", r), 64'(bus.f1_ready_o), 64'(tbl[r].e_ready));
         chk($sformatf("vec%0d_occ", r), 64'(bus.occupancy_o), 64'(tbl[r].e_occ));
         chk($sformatf("vec%0d_pc0", r), bus.decoder_pc_o[63:0], tbl[r].e_pc0);
         chk($sformatf("vec%0d_pc1", r), bus.decoder_pc_o[127:64], tbl[r].e_pc1);
         chk($sformatf("vec%0d_endsim", r), 64'(bus.decoder_endsim_o), 64'(tbl[r].e_endsim));
         @(posedge clk); #1;
      end

      // Asynchronous reset in the middle of operation.
      drive(1'b0, 2'b11, 64'h7000, 64'h7004, NOP, NOP, 2'd0);
      @(posedge clk); #1;
      chk("pre_async_occ", 64'(bus.occupancy_o), 64'h2);
      drive(1'b0, 2'b00, 64'h0, 64'h0, NOP, NOP, 2'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_occ", 64'(bus.occupancy_o), 64'h0);
      chk("async_rst_valid", 64'(bus.decoder_valid_o), 64'h0);
      chk("async_rst_ready", 64'(bus.f1_ready_o), 64'h1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      mq.delete();

      // Random traffic against the reference queue.
      for (int c = 0; c < 500; c++) begin
         logic        fl;
         logic [1:0]  v;
         logic [1:0]  is;
         logic [63:0] p [2];
         logic [31:0] ins [2];
         int unsigned sz, avail, k, d;
         fl = ($urandom_range(0, 15) == 0);
         v  = 2'($urandom);
         for (int j = 0; j < 2; j++) begin
            p[j]   = {32'($urandom), 32'($urandom)};
            ins[j] = ($urandom_range(0, 3) == 0) ? END : $urandom();
         end
         sz    = mq.size();
         avail = (sz < WIDTH) ? sz : WIDTH;
         is    = fl ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, avail));
         drive(fl, v, p[0], p[1], ins[0], ins[1], is);
         #2;
         chk("rnd_ready", 64'(bus.f1_ready_o), 64'(!fl && (DEPTH - sz >= WIDTH)));
         chk("rnd_occ", 64'(bus.occupancy_o), 64'(sz));
         for (int j = 0; j < 2; j++) begin
            logic [63:0] epc;
            logic [31:0] einst;
            logic        ev;
            ev    = (sz > j) && !fl;
            epc   = (sz > j) ? mq[j][95:32] : 64'h0;
            einst = (sz > j) ? mq[j][31:0] : 32'h0;
            chk($sformatf("rnd_valid%0d", j), 64'(bus.decoder_valid_o[j]), 64'(ev));
            chk($sformatf("rnd_pc%0d", j), bus.decoder_pc_o[j*64 +: 64], epc);
            chk($sformatf("rnd_inst%0d", j), 64'(bus.decoder_inst_o[j*32 +: 32]), 64'(einst));
            chk($sformatf("rnd_endsim%0d", j), 64'(bus.decoder_endsim_o[j]),
                64'(ev && einst == END));
         end
         @(posedge clk); #1;
         if (fl) begin
            mq.delete();
         end else begin
            k = v[0] ? (v[1] ? 2 : 1) : 0;
            d = (is < avail) ? is : avail;
            for (int n = 0; n < d; n++) void'(mq.pop_front());
            if (DEPTH - sz >= WIDTH) begin
               for (int n = 0; n < k; n++) mq.push_back({p[n], ins[n]});
            end
         end
      end

      drive(1'b0, 2'b00, 64'h0, 64'h0, NOP, NOP, 2'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
